// File: rtl/ctrl_window_checker_if.sv
// ctrl_window_checker_if: trigger/match inputs and result outputs of the window checker.
interface ctrl_window_checker_if #(
  parameter int NUM_CH = 12,
  parameter int CNT_WIDTH = 16
) ();
  logic enable;
  logic clear;
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] pass_pulse;
  logic [NUM_CH-1:0] fail_pulse;
  logic [NUM_CH-1:0] fail_sticky;
  logic [NUM_CH-1:0] ovf_sticky;
  logic any_fail;
  logic [CNT_WIDTH-1:0] pass_count;
  logic [CNT_WIDTH-1:0] fail_count;
  modport master (
    output enable, clear, trig, match,
    input pass_pulse, fail_pulse, fail_sticky, ovf_sticky, any_fail, pass_count, fail_count
  );
  modport slave (
    input enable, clear, trig, match,
    output pass_pulse, fail_pulse, fail_sticky, ovf_sticky, any_fail, pass_count, fail_count
  );
endinterface

// File: rtl/ctrl_window_checker.sv
// ctrl_window_checker: per-channel check that each trigger is answered within [MIN_DLY, MAX_DLY] cycles.
module ctrl_window_checker #(
  parameter int NUM_CH = 12,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 5,
  parameter int DEPTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  ctrl_window_checker_if.slave bus
);
  localparam int AW = $clog2(MAX_DLY + 1);
  localparam logic [AW-1:0] MIN_A = AW'(MIN_DLY);
  localparam logic [AW-1:0] MAX_A = AW'(MAX_DLY);
  localparam logic [AW-1:0] ONE_A = AW'(1);
  logic [DEPTH-1:0] valid_q [NUM_CH];
  logic [DEPTH-1:0] valid_d [NUM_CH];
  logic [AW-1:0] age_q [NUM_CH][DEPTH];
  logic [AW-1:0] age_d [NUM_CH][DEPTH];
  logic [NUM_CH-1:0] pass_q, pass_d, fail_q, fail_d;
  logic [NUM_CH-1:0] fail_sticky_q, fail_sticky_d, ovf_sticky_q, ovf_sticky_d;
  logic [CNT_WIDTH-1:0] pass_count_q, pass_count_d, fail_count_q, fail_count_d;
  logic [CNT_WIDTH:0] pass_sum, fail_sum;
  logic [DEPTH-1:0] ret, alloc;
  logic [AW-1:0] best_age;
  // A new slot is stored with age 1: it holds age 0 only during its trigger cycle, where it is never eligible.
  always_comb begin
    valid_d = valid_q;
    age_d = age_q;
    pass_d = '0;
    fail_d = '0;
    fail_sticky_d = fail_sticky_q;
    ovf_sticky_d = ovf_sticky_q;
    ret = '0;
    alloc = '0;
    best_age = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ret = '0;
      alloc = '0;
      best_age = '0;
      for (int s = 0; s < DEPTH; s++) begin
        if (bus.match[c] && valid_q[c][s] && age_q[c][s] >= MIN_A && age_q[c][s] <= MAX_A && age_q[c][s] > best_age) begin
          ret = '0;
          ret[s] = 1'b1;
          best_age = age_q[c][s];
        end
        if (!valid_q[c][s] && alloc == '0) alloc[s] = 1'b1;
      end
      alloc = (bus.enable && bus.trig[c]) ? alloc : '0;
      for (int s = 0; s < DEPTH; s++) begin
        if (ret[s]) valid_d[c][s] = 1'b0;
        else if (valid_q[c][s] && age_q[c][s] == MAX_A) begin
          valid_d[c][s] = 1'b0;
          fail_d[c] = 1'b1;
        end else if (valid_q[c][s]) age_d[c][s] = age_q[c][s] + ONE_A;
        if (alloc[s]) begin
          valid_d[c][s] = 1'b1;
          age_d[c][s] = ONE_A;
        end
      end
      pass_d[c] = |ret;
      ovf_sticky_d[c] = ovf_sticky_q[c] | (bus.enable & bus.trig[c] & (&valid_q[c]));
    end
    fail_sticky_d = fail_sticky_q | fail_d;
    pass_sum = {1'b0, pass_count_q} + (CNT_WIDTH+1)'($countones(pass_d));
    fail_sum = {1'b0, fail_count_q} + (CNT_WIDTH+1)'($countones(fail_d));
    pass_count_d = pass_sum[CNT_WIDTH] ? '1 : pass_sum[CNT_WIDTH-1:0];
    fail_count_d = fail_sum[CNT_WIDTH] ? '1 : fail_sum[CNT_WIDTH-1:0];
    if (bus.clear) begin
      valid_d = '{default: '0};
      age_d = '{default: '0};
      pass_d = '0;
      fail_d = '0;
      fail_sticky_d = '0;
      ovf_sticky_d = '0;
      pass_count_d = '0;
      fail_count_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= '{default: '0};
      age_q <= '{default: '0};
      pass_q <= '0;
      fail_q <= '0;
      fail_sticky_q <= '0;
      ovf_sticky_q <= '0;
      pass_count_q <= '0;
      fail_count_q <= '0;
    end else begin
      valid_q <= valid_d;
      age_q <= age_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      fail_sticky_q <= fail_sticky_d;
      ovf_sticky_q <= ovf_sticky_d;
      pass_count_q <= pass_count_d;
      fail_count_q <= fail_count_d;
    end
  assign bus.pass_pulse = pass_q;
  assign bus.fail_pulse = fail_q;
  assign bus.fail_sticky = fail_sticky_q;
  assign bus.ovf_sticky = ovf_sticky_q;
  assign bus.any_fail = |fail_sticky_q;
  assign bus.pass_count = pass_count_q;
  assign bus.fail_count = fail_count_q;
endmodule

// File: tb/tb_ctrl_window_checker.sv
// tb_ctrl_window_checker: directed checks of window pass/fail, overflow, clear, reset and saturation.
module tb_ctrl_window_checker;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  ctrl_window_checker_if #(.NUM_CH(12), .CNT_WIDTH(16)) bus ();
  ctrl_window_checker dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input logic [11:0] t, input logic [11:0] m);
    bus.trig = t;
    bus.match = m;
    step();
    bus.trig = '0;
    bus.match = '0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0);
  endtask
  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.clear = 1'b0;
    bus.trig = '0;
    bus.match = '0;
    #2;
    chk("rst_pass_count", bus.pass_count, 0);
    chk("rst_fail_sticky", bus.fail_sticky, 0);
    chk("rst_any_fail", bus.any_fail, 0);
    step();
    rst = 1'b0;
    step();
    // pass on channel 3 at offset 3
    cyc(12'h008, 0);
    idle(2);
    cyc(0, 12'h008);
    chk("t1_pass_pulse", bus.pass_pulse, 12'h008);
    chk("t1_pass_count", bus.pass_count, 1);
    chk("t1_fail_pulse", bus.fail_pulse, 0);
    idle(1);
    chk("t1_pulse_gone", bus.pass_pulse, 0);
    idle(6);
    chk("t1_no_fail", bus.fail_count, 0);
    do_clear();
    // channel 0: same-cycle match ignored, expiry, late match ignored
    cyc(12'h001, 12'h001);
    idle(4);
    chk("t2_no_early_fail", bus.fail_pulse, 0);
    idle(1);
    chk("t2_fail_pulse", bus.fail_pulse, 12'h001);
    chk("t2_fail_sticky", bus.fail_sticky, 12'h001);
    chk("t2_any_fail", bus.any_fail, 1);
    chk("t2_fail_count", bus.fail_count, 1);
    cyc(0, 12'h001);
    chk("t2_late_match", bus.pass_pulse, 0);
    chk("t2_pass_count", bus.pass_count, 0);
    chk("t2_sticky_held", bus.fail_sticky, 12'h001);
    do_clear();
    // channel 5: oldest window retires first
    cyc(12'h020, 0);
    cyc(12'h020, 0);
    cyc(12'h020, 0);
    cyc(0, 12'h020);
    chk("t3_pass_pulse", bus.pass_pulse, 12'h020);
    chk("t3_pass_count", bus.pass_count, 1);
    idle(2);
    chk("t3_no_fail_16", bus.fail_pulse, 0);
    idle(1);
    chk("t3_fail_17", bus.fail_pulse, 12'h020);
    idle(1);
    chk("t3_fail_18", bus.fail_pulse, 12'h020);
    chk("t3_fail_count", bus.fail_count, 2);
    idle(1);
    chk("t3_fail_done", bus.fail_pulse, 0);
    do_clear();
    // channel 2: fifth trigger overflows the queue
    cyc(12'h004, 0);
    cyc(12'h004, 0);
    cyc(12'h004, 0);
    cyc(12'h004, 0);
    chk("t4_no_ovf_yet", bus.ovf_sticky, 0);
    cyc(12'h004, 0);
    chk("t4_ovf", bus.ovf_sticky, 12'h004);
    idle(1);
    chk("t4_fail_16", bus.fail_pulse, 12'h004);
    chk("t4_fail_count_16", bus.fail_count, 1);
    idle(3);
    chk("t4_fail_19", bus.fail_pulse, 12'h004);
    chk("t4_fail_count", bus.fail_count, 4);
    idle(1);
    chk("t4_fail_done", bus.fail_pulse, 0);
    chk("t4_fail_count_end", bus.fail_count, 4);
    do_clear();
    // channels 1 and 7 matched exactly at MAX_DLY
    cyc(12'h082, 0);
    idle(4);
    cyc(0, 12'h082);
    chk("t5_pass_pulse", bus.pass_pulse, 12'h082);
    chk("t5_pass_count", bus.pass_count, 2);
    chk("t5_no_fail", bus.fail_pulse, 0);
    idle(1);
    chk("t5_no_late_fail", bus.fail_pulse, 0);
    // enable gating and MIN_DLY boundary
    bus.enable = 1'b0;
    cyc(12'h200, 0);
    bus.enable = 1'b1;
    idle(7);
    chk("t7_disabled_trig", bus.fail_sticky, 0);
    cyc(12'h200, 0);
    bus.enable = 1'b0;
    idle(5);
    chk("t7_fail_while_disabled", bus.fail_pulse, 12'h200);
    chk("t7_fail_count", bus.fail_count, 1);
    bus.enable = 1'b1;
    cyc(12'h040, 0);
    cyc(0, 12'h040);
    chk("t7_min_pass", bus.pass_pulse, 12'h040);
    chk("t7_pass_count", bus.pass_count, 3);
    // clear overrides trig/match and kills pending windows
    cyc(12'h010, 0);
    idle(1);
    bus.clear = 1'b1;
    cyc(12'h010, 12'h010);
    bus.clear = 1'b0;
    chk("t6_clr_pass_pulse", bus.pass_pulse, 0);
    chk("t6_clr_pass_count", bus.pass_count, 0);
    chk("t6_clr_fail_count", bus.fail_count, 0);
    chk("t6_clr_sticky", bus.fail_sticky, 0);
    chk("t6_clr_any_fail", bus.any_fail, 0);
    idle(6);
    chk("t6_clr_no_fail", bus.fail_count, 0);
    cyc(12'h010, 0);
    idle(6);
    chk("t6_pre_rst_sticky", bus.fail_sticky, 12'h010);
    cyc(12'h010, 0);
    idle(1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_sticky", bus.fail_sticky, 0);
    chk("t6_rst_any_fail", bus.any_fail, 0);
    chk("t6_rst_fail_count", bus.fail_count, 0);
    #2;
    rst = 1'b0;
    step();
    idle(6);
    chk("t6_rst_no_fail", bus.fail_sticky, 0);
    // pass_count saturation with every channel passing every cycle
    bus.trig = '1;
    bus.match = '1;
    for (int i = 0; i < 5500; i++) step();
    chk("t8_sat_pass", bus.pass_count, 16'hFFFF);
    step();
    chk("t8_sat_hold", bus.pass_count, 16'hFFFF);
    chk("t8_sat_no_fail", bus.fail_count, 0);
    chk("t8_sat_no_ovf", bus.ovf_sticky, 0);
    bus.trig = '0;
    bus.match = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
